banco_registradores_param: RTL

- Parametrised successor to the nRISC 8-bit register bank. It provides one write port, two synchronous read ports and one always-visible accumulator read.
- It adds same-cycle write-to-read bypass, an optional hardwired zero register, a read-hold enable, and a per-register pending-write scoreboard for hazard detection.
- It sits between decode (read addresses, mark) and writeback (write port) in the datapath.
- All state updates on a single clock edge.

---
 rtl/nrisc_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/banco_registradores_param.sv | 106 ++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// Shared nRISC register-file types and defaults.
// Typedefs describe the default 8-bit / 4-register configuration.
package nrisc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int ZERO_IDX   = 0;

  typedef logic [ADDR_W_DEF-1:0] regaddr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by mark, cleared by write.
// Lookups return either the current or the post-edge vector depending on BYPASS.
module regfile_scoreboard
  import nrisc_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic [ADDR_W-1:0] look_a,
  input  logic [ADDR_W-1:0] look_b,
  output logic              hit_a,
  output logic              hit_b
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;
  logic [NREG-1:0] view;

  // Mark is applied after the clear so a same-cycle mark overrides the write.
  // NOTE: start from a full default so every path assigns pend_next; no latch.
  always_comb begin
    pend_next = pend;
    if (wr_en && !(ZERO_REG && wr_addr == ZERO_ADDR))
      pend_next[wr_addr] = 1'b0;
    if (mark_en && !(ZERO_REG && mark_addr == ZERO_ADDR))
      pend_next[mark_addr] = 1'b1;
  end

  // NOTE: state uses non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= pend_next;
  end

  always_comb begin
    view = BYPASS ? pend_next : pend;
  end

  assign hit_a = view[look_a];
  assign hit_b = view[look_b];

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised nRISC register bank: one write port, two registered read ports,
// a free-running accumulator read, optional write bypass and zero register.
module banco_registradores_param
  import nrisc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  parameter int ACC_IDX  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_a,
  output logic              pend_b,
  output logic [DATA_W-1:0] rd_data_acc
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ACC_ADDR  = ADDR_W'(ACC_IDX);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  generate
    if (ZERO_REG && ACC_IDX == ZERO_IDX) begin : g_bad_acc_zero
      $error("ACC_IDX must not select the hardwired zero register");
    end
    if (ACC_IDX < 0 || ACC_IDX >= NREG) begin : g_bad_acc_range
      $error("ACC_IDX out of range");
    end
  endgenerate

  logic [DATA_W-1:0] regs      [NREG];
  logic [DATA_W-1:0] regs_next [NREG];
  logic [DATA_W-1:0] view      [NREG];
  logic              wr_ok;
  logic              hit_a;
  logic              hit_b;

  // With ZERO_REG the zero slot is never written, so it reads 0 on its own.
  assign wr_ok = wr_en && !(ZERO_REG && wr_addr == ZERO_ADDR);

  always_comb begin
    regs_next = regs;
    if (wr_ok) regs_next[wr_addr] = wr_data;
  end

  always_comb begin
    view = BYPASS ? regs_next : regs;
  end

  // NOTE: the array sits on the async reset because reset must clear all
  // register contents; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      regs <= regs_next;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .mark_en   (mark_en),
    .mark_addr (mark_addr),
    .look_a    (rd_addr_a),
    .look_b    (rd_addr_b),
    .hit_a     (hit_a),
    .hit_b     (hit_b)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_a   <= '0;
      rd_data_b   <= '0;
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      rd_data_acc <= '0;
    end else begin
      rd_data_acc <= view[ACC_ADDR];
      if (rd_en) begin
        rd_data_a <= view[rd_addr_a];
        rd_data_b <= view[rd_addr_b];
        pend_a    <= hit_a;
        pend_b    <= hit_b;
      end
    end
  end

endmodule
